// File: rtl/regfile_wb_ctrl_pkg.sv
// regfile_wb_ctrl_pkg: shared defaults and encodings for the register-file write-side controller.
// Contents: DW/AW/QDEPTH defaults, zero-register index, entry valid encodings, reset-active level.
package regfile_wb_ctrl_pkg;
   localparam int DW_DEF     = 32;
   localparam int AW_DEF     = 5;
   localparam int QDEPTH_DEF = 2;
   localparam int ZERO_REG   = 0;
   localparam logic VALID      = 1'b1;
   localparam logic INVALID    = 1'b0;
   localparam logic RST_ACTIVE = 1'b0;
endpackage

// File: rtl/regfile_wb_ctrl_wb_queue.sv
// wb_queue: QDEPTH-entry FIFO of {valid, addr, data} for multi-cycle results.
// Ports: clk, rst (async active-low); push_i/push_addr_i/push_data_i; pop_i;
//        kill_en_i/kill_addr_i invalidate matching entries; head_*_o; full_o/empty_o;
//        ent_*_o expose every slot, index 0 = head (oldest).
module wb_queue
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF,
   parameter int QDEPTH = QDEPTH_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [AW-1:0]     push_addr_i,
   input  logic [DW-1:0]     push_data_i,
   input  logic              pop_i,
   input  logic              kill_en_i,
   input  logic [AW-1:0]     kill_addr_i,
   output logic              head_valid_o,
   output logic [AW-1:0]     head_addr_o,
   output logic [DW-1:0]     head_data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [QDEPTH-1:0] ent_valid_o,
   output logic [AW-1:0]     ent_addr_o [QDEPTH],
   output logic [DW-1:0]     ent_data_o [QDEPTH]
);
   localparam int CW = $clog2(QDEPTH + 1);
   logic [QDEPTH-1:0] v_q, v_d;
   logic [AW-1:0]     a_q [QDEPTH];
   logic [AW-1:0]     a_d [QDEPTH];
   logic [DW-1:0]     d_q [QDEPTH];
   logic [DW-1:0]     d_d [QDEPTH];
   logic [CW-1:0]     count_q, count_d, widx;
   // Shift-down organisation: slot 0 is always the head, so the forwarding
   // search sees entries in age order without pointer arithmetic.
   always_comb begin
      v_d = v_q;
      a_d = a_q;
      d_d = d_q;
      widx = count_q - CW'(pop_i);
      if (pop_i) begin
         for (int i = 0; i < QDEPTH - 1; i++) begin
            v_d[i] = v_q[i+1];
            a_d[i] = a_q[i+1];
            d_d[i] = d_q[i+1];
         end
         v_d[QDEPTH-1] = INVALID;
      end
      // Killed slots stay occupied; only their valid bit drops.
      for (int i = 0; i < QDEPTH; i++)
         if (kill_en_i && a_d[i] == kill_addr_i) v_d[i] = INVALID;
      for (int i = 0; i < QDEPTH; i++)
         if (push_i && CW'(i) == widx) begin
            v_d[i] = VALID;
            a_d[i] = push_addr_i;
            d_d[i] = push_data_i;
         end
      count_d = count_q + CW'(push_i) - CW'(pop_i);
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q     <= '0;
         count_q <= '0;
         for (int i = 0; i < QDEPTH; i++) begin
            a_q[i] <= '0;
            d_q[i] <= '0;
         end
      end else begin
         v_q     <= v_d;
         a_q     <= a_d;
         d_q     <= d_d;
         count_q <= count_d;
      end
   end
   assign head_valid_o = v_q[0];
   assign head_addr_o  = a_q[0];
   assign head_data_o  = d_q[0];
   assign full_o       = count_q == CW'(QDEPTH);
   assign empty_o      = count_q == '0;
   assign ent_valid_o  = v_q;
   assign ent_addr_o   = a_q;
   assign ent_data_o   = d_q;
endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: merges pipeline write-back and queued multi-cycle results onto one register-file write port.
// Ports: clk, rst (async active-low); p_* pipeline results (always accepted);
//        m_valid/m_ready/m_* multi-cycle handshake; we/waddr/wdata registered write port;
//        fa_*/fb_* forwarding lookups; busy = queue non-empty or we.
// Build option: REGFILE_WB_FWD_EN enables the forwarding search; otherwise lookups return 0.
module regfile_wb_ctrl
   import regfile_wb_ctrl_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF,
   parameter int QDEPTH = QDEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p_valid,
   input  logic [AW-1:0] p_waddr,
   input  logic [DW-1:0] p_wdata,
   input  logic          m_valid,
   output logic          m_ready,
   input  logic [AW-1:0] m_waddr,
   input  logic [DW-1:0] m_wdata,
   output logic          we,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] wdata,
   input  logic [AW-1:0] fa_addr,
   output logic          fa_hit,
   output logic [DW-1:0] fa_data,
   input  logic [AW-1:0] fb_addr,
   output logic          fb_hit,
   output logic [DW-1:0] fb_data,
   output logic          busy
);
   localparam logic [AW-1:0] ZR = AW'(ZERO_REG);
   logic          we_q, we_d;
   logic [AW-1:0] waddr_q, waddr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          p_wr, m_acc, m_live, pop, bypass, push;
   logic          head_valid, full, empty;
   logic [AW-1:0] head_addr;
   logic [DW-1:0] head_data;
   logic [QDEPTH-1:0] ev;
   logic [AW-1:0]     ea [QDEPTH];
   logic [DW-1:0]     ed [QDEPTH];
   // Slot availability comes from the registered count only, and the port is
   // closed for the whole time reset is held.
   assign m_ready = (rst != RST_ACTIVE) && !full;
   assign m_acc   = m_valid && m_ready;
   assign m_live  = m_acc && m_waddr != ZR;
   assign p_wr    = p_valid && p_waddr != ZR;
   assign pop     = !p_wr && !empty;
   assign bypass  = !p_wr && empty && m_live;
   // A same-cycle m write to the pipeline's destination is older and is dropped.
   assign push    = m_live && !bypass && !(p_wr && m_waddr == p_waddr);
   wb_queue #(.DW(DW), .AW(AW), .QDEPTH(QDEPTH)) u_queue (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_addr_i (m_waddr),
      .push_data_i (m_wdata),
      .pop_i       (pop),
      .kill_en_i   (p_wr),
      .kill_addr_i (p_waddr),
      .head_valid_o(head_valid),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .full_o      (full),
      .empty_o     (empty),
      .ent_valid_o (ev),
      .ent_addr_o  (ea),
      .ent_data_o  (ed)
   );
   // A popped killed entry issues nothing; address/data hold.
   always_comb begin
      we_d    = p_wr || (pop && head_valid) || bypass;
      waddr_d = p_wr ? p_waddr : (pop && head_valid) ? head_addr : bypass ? m_waddr : waddr_q;
      wdata_d = p_wr ? p_wdata : (pop && head_valid) ? head_data : bypass ? m_wdata : wdata_q;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end
   assign we    = we_q;
   assign waddr = waddr_q;
   assign wdata = wdata_q;
   assign busy  = !empty || we_q;
`ifdef REGFILE_WB_FWD_EN
   // Oldest first so later (younger) matches override: output register, then head..tail.
   always_comb begin
      fa_hit  = we_q && waddr_q == fa_addr && fa_addr != ZR;
      fa_data = fa_hit ? wdata_q : '0;
      fb_hit  = we_q && waddr_q == fb_addr && fb_addr != ZR;
      fb_data = fb_hit ? wdata_q : '0;
      for (int i = 0; i < QDEPTH; i++) begin
         if (ev[i] && ea[i] == fa_addr && fa_addr != ZR) begin
            fa_hit  = 1'b1;
            fa_data = ed[i];
         end
         if (ev[i] && ea[i] == fb_addr && fb_addr != ZR) begin
            fb_hit  = 1'b1;
            fb_data = ed[i];
         end
      end
   end
`else
   logic unused_fwd;
   always_comb begin
      unused_fwd = ^{fa_addr, fb_addr, ev};
      for (int i = 0; i < QDEPTH; i++) unused_fwd = unused_fwd ^ (^ea[i]) ^ (^ed[i]);
   end
   assign fa_hit  = 1'b0;
   assign fa_data = '0;
   assign fb_hit  = 1'b0;
   assign fb_data = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb_regfile_wb_ctrl: directed self-checking bench for regfile_wb_ctrl (QDEPTH=2).
module tb_regfile_wb_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        p_valid = 1'b0;
   logic [4:0]  p_waddr = '0;
   logic [31:0] p_wdata = '0;
   logic        m_valid = 1'b0;
   logic        m_ready;
   logic [4:0]  m_waddr = '0;
   logic [31:0] m_wdata = '0;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [4:0]  fa_addr = '0;
   logic        fa_hit;
   logic [31:0] fa_data;
   logic [4:0]  fb_addr = '0;
   logic        fb_hit;
   logic [31:0] fb_data;
   logic        busy;
   int vectors = 0;
   int errors = 0;

   regfile_wb_ctrl dut (
      .clk(clk), .rst(rst),
      .p_valid(p_valid), .p_waddr(p_waddr), .p_wdata(p_wdata),
      .m_valid(m_valid), .m_ready(m_ready), .m_waddr(m_waddr), .m_wdata(m_wdata),
      .we(we), .waddr(waddr), .wdata(wdata),
      .fa_addr(fa_addr), .fa_hit(fa_hit), .fa_data(fa_data),
      .fb_addr(fb_addr), .fb_hit(fb_hit), .fb_data(fb_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      p_valid = 1'b0;
      m_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #3;
      vectors++;
      if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0 || m_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset: got we=%b waddr=%0d wdata=%h m_ready=%b busy=%b want 0 0 0 0 0", we, waddr, wdata, m_ready, busy);
      end
      step();
      rst = 1'b1;
      step();
      vectors++;
      if (m_ready !== 1'b1 || we !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got m_ready=%b we=%b want 1 0", m_ready, we);
      end
   endtask

   task automatic test_pipe();
      p_valid = 1'b1; p_waddr = 5'd3; p_wdata = 32'h11;
      step();
      p_valid = 1'b0;
      vectors++;
      if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h11) begin
         errors++;
         $display("FAIL pipe_wr: got we=%b waddr=%0d wdata=%h want 1 3 11", we, waddr, wdata);
      end
      step();
      vectors++;
      if (we !== 1'b0 || waddr !== 5'd3 || wdata !== 32'h11 || busy !== 1'b0) begin
         errors++;
         $display("FAIL pipe_idle: got we=%b waddr=%0d wdata=%h busy=%b want 0 3 11 0", we, waddr, wdata, busy);
      end
   endtask

   task automatic test_r0();
      p_valid = 1'b1; p_waddr = 5'd0; p_wdata = 32'hDEAD;
      step();
      p_valid = 1'b0;
      vectors++;
      if (we !== 1'b0 || waddr !== 5'd3) begin
         errors++;
         $display("FAIL p_r0: got we=%b waddr=%0d want 0 3", we, waddr);
      end
      m_valid = 1'b1; m_waddr = 5'd0; m_wdata = 32'hBEEF;
      vectors++;
      if (m_ready !== 1'b1) begin
         errors++;
         $display("FAIL m_r0_ready: got %b want 1", m_ready);
      end
      step();
      m_valid = 1'b0;
      vectors++;
      if (we !== 1'b0 || busy !== 1'b0 || wdata !== 32'h11) begin
         errors++;
         $display("FAIL m_r0_drop: got we=%b busy=%b wdata=%h want 0 0 11", we, busy, wdata);
      end
   endtask

   task automatic test_bypass();
      m_valid = 1'b1; m_waddr = 5'd7; m_wdata = 32'hAA;
      vectors++;
      if (m_ready !== 1'b1) begin
         errors++;
         $display("FAIL bypass_ready: got %b want 1", m_ready);
      end
      step();
      m_valid = 1'b0;
      vectors++;
      if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'hAA) begin
         errors++;
         $display("FAIL bypass_wr: got we=%b waddr=%0d wdata=%h want 1 7 aa", we, waddr, wdata);
      end
      step();
   endtask

   task automatic test_starve();
      logic       exp_rdy [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [4:0] exp_a   [7] = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd20, 5'd21, 5'd22};
      logic [31:0] exp_d  [7] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200, 32'h201, 32'h202};
      int k = 0;
      logic acc;
      for (int i = 0; i < 7; i++) begin
         p_valid = i < 4;
         p_waddr = 5'(10 + i);
         p_wdata = 32'h100 + 32'(i);
         m_valid = k < 3;
         m_waddr = 5'(20 + k);
         m_wdata = 32'h200 + 32'(k);
         vectors++;
         if (m_ready !== exp_rdy[i]) begin
            errors++;
            $display("FAIL starve_ready[%0d]: got %b want %b", i, m_ready, exp_rdy[i]);
         end
         acc = m_valid && m_ready;
         step();
         if (acc) k++;
         vectors++;
         if (we !== 1'b1 || waddr !== exp_a[i] || wdata !== exp_d[i]) begin
            errors++;
            $display("FAIL starve_wr[%0d]: got we=%b waddr=%0d wdata=%h want 1 %0d %h", i, we, waddr, wdata, exp_a[i], exp_d[i]);
         end
      end
      idle_inputs();
      step();
      vectors++;
      if (we !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL starve_drain: got we=%b busy=%b want 0 0", we, busy);
      end
   endtask

   task automatic test_kill();
      p_valid = 1'b1; p_waddr = 5'd1; p_wdata = 32'h01;
      m_valid = 1'b1; m_waddr = 5'd5; m_wdata = 32'h55;
      step();
      m_valid = 1'b0;
      p_waddr = 5'd5; p_wdata = 32'h66;
      step();
      p_valid = 1'b0;
      vectors++;
      if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h66 || busy !== 1'b1) begin
         errors++;
         $display("FAIL kill_pwr: got we=%b waddr=%0d wdata=%h busy=%b want 1 5 66 1", we, waddr, wdata, busy);
      end
      step();
      vectors++;
      if (we !== 1'b0 || waddr !== 5'd5 || wdata !== 32'h66 || busy !== 1'b0) begin
         errors++;
         $display("FAIL kill_pop: got we=%b waddr=%0d wdata=%h busy=%b want 0 5 66 0", we, waddr, wdata, busy);
      end
      p_valid = 1'b1; p_waddr = 5'd6; p_wdata = 32'h77;
      m_valid = 1'b1; m_waddr = 5'd6; m_wdata = 32'h88;
      step();
      idle_inputs();
      vectors++;
      if (we !== 1'b1 || waddr !== 5'd6 || wdata !== 32'h77 || busy !== 1'b1) begin
         errors++;
         $display("FAIL kill_same_p: got we=%b waddr=%0d wdata=%h busy=%b want 1 6 77 1", we, waddr, wdata, busy);
      end
      step();
      vectors++;
      if (we !== 1'b0 || busy !== 1'b0 || wdata !== 32'h77) begin
         errors++;
         $display("FAIL kill_same_m: got we=%b busy=%b wdata=%h want 0 0 77", we, busy, wdata);
      end
   endtask

   task automatic test_fwd();
      logic        eh;
      logic [31:0] ed;
      p_valid = 1'b1; p_waddr = 5'd2; p_wdata = 32'h22;
      m_valid = 1'b1; m_waddr = 5'd9; m_wdata = 32'h99;
      step();
      idle_inputs();
      fa_addr = 5'd9; fb_addr = 5'd2;
      #1;
`ifdef REGFILE_WB_FWD_EN
      eh = 1'b1; ed = 32'h99;
`else
      eh = 1'b0; ed = 32'h0;
`endif
      vectors++;
      if (fa_hit !== eh || fa_data !== ed) begin
         errors++;
         $display("FAIL fwd_queue: got hit=%b data=%h want %b %h", fa_hit, fa_data, eh, ed);
      end
`ifdef REGFILE_WB_FWD_EN
      ed = 32'h22;
`endif
      vectors++;
      if (fb_hit !== eh || fb_data !== ed) begin
         errors++;
         $display("FAIL fwd_outreg: got hit=%b data=%h want %b %h", fb_hit, fb_data, eh, ed);
      end
      fa_addr = 5'd0; fb_addr = 5'd4;
      #1;
      vectors++;
      if (fa_hit !== 1'b0 || fa_data !== 32'h0 || fb_hit !== 1'b0 || fb_data !== 32'h0) begin
         errors++;
         $display("FAIL fwd_miss: got a=%b/%h b=%b/%h want 0/0 0/0", fa_hit, fa_data, fb_hit, fb_data);
      end
      p_valid = 1'b1; p_waddr = 5'd4; p_wdata = 32'h44;
      m_valid = 1'b1; m_waddr = 5'd9; m_wdata = 32'h9A;
      step();
      idle_inputs();
      fa_addr = 5'd9;
      #1;
`ifdef REGFILE_WB_FWD_EN
      ed = 32'h9A;
`else
      ed = 32'h0;
`endif
      vectors++;
      if (fa_hit !== eh || fa_data !== ed) begin
         errors++;
         $display("FAIL fwd_youngest: got hit=%b data=%h want %b %h", fa_hit, fa_data, eh, ed);
      end
      step();
      vectors++;
      if (we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h99) begin
         errors++;
         $display("FAIL fwd_drain0: got we=%b waddr=%0d wdata=%h want 1 9 99", we, waddr, wdata);
      end
      step();
      vectors++;
      if (we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h9A) begin
         errors++;
         $display("FAIL fwd_drain1: got we=%b waddr=%0d wdata=%h want 1 9 9a", we, waddr, wdata);
      end
      step();
      fa_addr = 5'd0; fb_addr = 5'd0;
   endtask

   task automatic test_reset_mid();
      p_valid = 1'b1; p_waddr = 5'd1; p_wdata = 32'h1;
      m_valid = 1'b1; m_waddr = 5'd11; m_wdata = 32'hB;
      step();
      p_waddr = 5'd2; p_wdata = 32'h2;
      m_waddr = 5'd12; m_wdata = 32'hC;
      step();
      idle_inputs();
      vectors++;
      if (we !== 1'b1 || m_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: got we=%b m_ready=%b busy=%b want 1 0 1", we, m_ready, busy);
      end
      #1 rst = 1'b0;
      #1;
      vectors++;
      if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0 || m_ready !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_async: got we=%b waddr=%0d wdata=%h m_ready=%b busy=%b want 0 0 0 0 0", we, waddr, wdata, m_ready, busy);
      end
      step();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (we !== 1'b0 || busy !== 1'b0 || m_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_stale[%0d]: got we=%b busy=%b m_ready=%b want 0 0 1", i, we, busy, m_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_pipe();
      test_r0();
      test_bypass();
      test_starve();
      test_kill();
      test_fwd();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
